// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side burst controller.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int MODE_DRAIN = 0;
  localparam int MODE_BURST = 1;
  localparam int ERR_CNT_W  = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_burst_rd_sync_bit.sv
// Multi-stage flip-flop synchroniser for a single-bit level signal.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q, sync_d;

  // Shift the raw level in at the bottom of the chain.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchroniser chain register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_burst_rd.sv
// Read-side controller for the dual-clock test FIFO: arms on full or an
// occupancy threshold, drains or reads fixed bursts, and checks the words
// against the write side's incrementing pattern.
module fifo_burst_rd
  import fifo_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int CNT_W       = 8,
  parameter int BURST_LEN   = 16,
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = 0
) (
  input  logic                 rd_clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [DATA_W-1:0]    fifo_rd_data,
  input  logic                 full,
  input  logic                 empty,
  input  logic                 almost_empty,
  input  logic [CNT_W-1:0]     rd_data_count,
  input  logic                 rd_rst_busy,
  input  logic                 err_clr,
  output logic                 fifo_rd_en,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  output logic                 burst_done,
  output logic                 data_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(BURST_LEN - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic                 rd_pend_q, rd_pend_d;
  logic                 out_valid_q, out_valid_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic [DATA_W-1:0]    exp_q, exp_d;
  logic                 data_err_q, data_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 full_sync;
  logic                 trigger;

  sync_bit #(.STAGES(SYNC_STAGES)) u_full_sync (
    .clk   (rd_clk),
    .rst_n (rst_n),
    .d     (full),
    .q     (full_sync)
  );

  // Reads only in READ, never into an empty FIFO or one resetting.
  assign fifo_rd_en = (state_q == READ) & ~empty & ~rd_rst_busy;
  assign burst_done = (state_q == DONE);
  assign trigger    = (MODE == MODE_BURST) ? (rd_data_count >= BURST_LEN_C) : full_sync;

  // Next-state and beat counter; FIFO reset aborts everything back to IDLE.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: if (enable && !rd_rst_busy) state_d = ARM;
      ARM: begin
        if (!enable)      state_d = IDLE;
        else if (trigger) state_d = READ;
      end
      READ: begin
        if (MODE == MODE_BURST) begin
          if (fifo_rd_en) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            if (beat_cnt_q == LAST_BEAT) state_d = DONE;
          end
        end else if (almost_empty) begin
          state_d = DONE;
        end
      end
      DONE: begin
        beat_cnt_d = '0;
        state_d    = enable ? ARM : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rd_rst_busy && state_q != IDLE) begin
      state_d    = IDLE;
      beat_cnt_d = '0;
    end
  end

  // Read pipeline (FIFO latency 1, then output register) and pattern check.
  always_comb begin
    rd_pend_d   = fifo_rd_en;
    out_valid_d = rd_pend_q;
    out_data_d  = rd_pend_q ? fifo_rd_data : out_data_q;
    exp_d       = exp_q;
    data_err_d  = data_err_q;
    err_cnt_d   = err_cnt_q;
    if (err_clr) begin
      data_err_d = 1'b0;
      err_cnt_d  = '0;
    end
    if (out_valid_q) begin
      exp_d = out_data_q + 1'b1;
      if (out_data_q != exp_q) begin
        data_err_d = 1'b1;
        err_cnt_d  = err_clr ? ERR_CNT_W'(1) : sat_inc(err_cnt_q);
      end
    end
  end

  // Control state registers.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Datapath and checker registers.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      exp_q       <= '0;
      data_err_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      rd_pend_q   <= rd_pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      exp_q       <= exp_d;
      data_err_q  <= data_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign data_err  = data_err_q;
  assign err_cnt   = err_cnt_q;

endmodule
